// File: rtl/regalu_pipe.sv
// ============================================================================
//  Module      : regalu_pipe
//  Description : Three-stage (ID/EX/WB) R-type ALU with internal register
//                file and valid/ready input handshake. Define
//                REGALU_FORWARDING_EN to build the EX/WB bypass network;
//                otherwise RAW hazards stall the input.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regalu_pipe #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    output logic              out_wen,
    output logic [4:0]        out_rd,
    output logic [DATA_W-1:0] out_result,
    output logic              out_ovf,
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam logic [3:0] c_OP_NOP = 4'd0;
    localparam logic [3:0] c_OP_ADD = 4'd1;
    localparam logic [3:0] c_OP_SUB = 4'd2;
    localparam logic [3:0] c_OP_AND = 4'd3;
    localparam logic [3:0] c_OP_OR  = 4'd4;
    localparam logic [3:0] c_OP_XOR = 4'd5;
    localparam logic [3:0] c_OP_NOR = 4'd6;
    localparam logic [3:0] c_OP_SLT = 4'd7;
    localparam logic [3:0] c_OP_SLL = 4'd8;
    localparam logic [3:0] c_OP_SRL = 4'd9;

    localparam logic [5:0] c_NUM_REGS = 6'(NUM_REGS);
    localparam logic [6:0] c_SH_LIMIT = 7'(DATA_W);
    localparam int         c_MSB      = DATA_W - 1;

    // Sized for the full 5-bit address space; entries at or above NUM_REGS stay zero
    logic [DATA_W-1:0] r_regs [0:31];

    logic [5:0]        w_opcode;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [4:0]        w_shamt;
    logic [5:0]        w_funct;
    logic [3:0]        w_op;
    logic              w_rd_ok;
    logic              w_stall;
    logic              w_accept;
    logic [DATA_W-1:0] w_rf_a;
    logic [DATA_W-1:0] w_rf_b;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;

    logic              r_ex_valid;
    logic              r_ex_wen;
    logic [4:0]        r_ex_rd;
    logic [3:0]        r_ex_op;
    logic [DATA_W-1:0] r_ex_a;
    logic [DATA_W-1:0] r_ex_b;
    logic [4:0]        r_ex_shamt;

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_sh_ok;
    logic [DATA_W-1:0] w_ex_result;
    logic              w_ex_ovf;

    logic              r_wb_valid;
    logic              r_wb_wen;
    logic [4:0]        r_wb_rd;
    logic [DATA_W-1:0] r_wb_result;
    logic              r_wb_ovf;

    function automatic logic [DATA_W-1:0] f_rf_read(input logic [4:0] addr);
        if ((addr != 5'd0) && ({1'b0, addr} < c_NUM_REGS)) begin
            return r_regs[addr];
        end
        return '0;
    endfunction

    // ---------------------------------------------------------------- ID stage
    assign w_opcode = in_instr[31:26];
    assign w_rs     = in_instr[25:21];
    assign w_rt     = in_instr[20:16];
    assign w_rd     = in_instr[15:11];
    assign w_shamt  = in_instr[10:6];
    assign w_funct  = in_instr[5:0];

    always_comb begin
        w_op = c_OP_NOP;
        if (w_opcode == 6'd0) begin
            case (w_funct)
                6'h20:   w_op = c_OP_ADD;
                6'h22:   w_op = c_OP_SUB;
                6'h24:   w_op = c_OP_AND;
                6'h25:   w_op = c_OP_OR;
                6'h26:   w_op = c_OP_XOR;
                6'h27:   w_op = c_OP_NOR;
                6'h2A:   w_op = c_OP_SLT;
                6'h00:   w_op = c_OP_SLL;
                6'h02:   w_op = c_OP_SRL;
                default: w_op = c_OP_NOP;
            endcase
        end
    end

    assign w_rd_ok = (w_rd != 5'd0) && ({1'b0, w_rd} < c_NUM_REGS);
    assign w_rf_a  = f_rf_read(w_rs);
    assign w_rf_b  = f_rf_read(w_rt);

`ifdef REGALU_FORWARDING_EN
    // A writing producer always has a nonzero rd, so matching r0 is impossible
    always_comb begin
        w_op_a = w_rf_a;
        w_op_b = w_rf_b;
        if (r_wb_wen && (r_wb_rd == w_rs)) w_op_a = r_wb_result;
        if (r_wb_wen && (r_wb_rd == w_rt)) w_op_b = r_wb_result;
        if (r_ex_wen && (r_ex_rd == w_rs)) w_op_a = w_ex_result;
        if (r_ex_wen && (r_ex_rd == w_rt)) w_op_b = w_ex_result;
    end
    assign w_stall = 1'b0;
`else
    assign w_op_a  = w_rf_a;
    assign w_op_b  = w_rf_b;
    assign w_stall = in_valid &&
                     ((r_ex_wen && ((r_ex_rd == w_rs) || (r_ex_rd == w_rt))) ||
                      (r_wb_wen && ((r_wb_rd == w_rs) || (r_wb_rd == w_rt))));
`endif

    assign in_ready = !rst && !w_stall;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_wen   <= 1'b0;
            r_ex_rd    <= 5'd0;
            r_ex_op    <= c_OP_NOP;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_shamt <= 5'd0;
        end else begin
            r_ex_valid <= w_accept;
            r_ex_wen   <= w_accept && (w_op != c_OP_NOP) && w_rd_ok;
            r_ex_rd    <= w_rd;
            r_ex_op    <= w_op;
            r_ex_a     <= w_op_a;
            r_ex_b     <= w_op_b;
            r_ex_shamt <= w_shamt;
        end
    end

    // ---------------------------------------------------------------- EX stage
    assign w_sum   = r_ex_a + r_ex_b;
    assign w_diff  = r_ex_a - r_ex_b;
    assign w_sh_ok = {2'b00, r_ex_shamt} < c_SH_LIMIT;

    always_comb begin
        w_ex_result = '0;
        w_ex_ovf    = 1'b0;
        case (r_ex_op)
            c_OP_ADD: begin
                w_ex_result = w_sum;
                w_ex_ovf    = (r_ex_a[c_MSB] == r_ex_b[c_MSB]) && (w_sum[c_MSB] != r_ex_a[c_MSB]);
            end
            c_OP_SUB: begin
                w_ex_result = w_diff;
                w_ex_ovf    = (r_ex_a[c_MSB] != r_ex_b[c_MSB]) && (w_diff[c_MSB] != r_ex_a[c_MSB]);
            end
            c_OP_AND: w_ex_result = r_ex_a & r_ex_b;
            c_OP_OR:  w_ex_result = r_ex_a | r_ex_b;
            c_OP_XOR: w_ex_result = r_ex_a ^ r_ex_b;
            c_OP_NOR: w_ex_result = ~(r_ex_a | r_ex_b);
            c_OP_SLT: w_ex_result = {{(DATA_W-1){1'b0}}, ($signed(r_ex_a) < $signed(r_ex_b))};
            c_OP_SLL: w_ex_result = w_sh_ok ? (r_ex_b << r_ex_shamt) : '0;
            c_OP_SRL: w_ex_result = w_sh_ok ? (r_ex_b >> r_ex_shamt) : '0;
            default:  w_ex_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid  <= 1'b0;
            r_wb_wen    <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_result <= '0;
            r_wb_ovf    <= 1'b0;
        end else begin
            r_wb_valid  <= r_ex_valid;
            r_wb_wen    <= r_ex_wen;
            r_wb_rd     <= r_ex_rd;
            r_wb_result <= w_ex_result;
            r_wb_ovf    <= w_ex_ovf;
        end
    end

    // ---------------------------------------------------------------- WB stage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_wb_wen) begin
            r_regs[r_wb_rd] <= r_wb_result;
        end
    end

    assign out_valid  = r_wb_valid;
    assign out_wen    = r_wb_wen;
    assign out_rd     = r_wb_rd;
    assign out_result = r_wb_result;
    assign out_ovf    = r_wb_ovf;
    assign dbg_rdata  = f_rf_read(dbg_raddr);

endmodule

`default_nettype wire

// File: tb/tb_regalu_pipe.sv
// ============================================================================
//  Module      : tb_regalu_pipe
//  Description : Scoreboard bench for regalu_pipe; a 32-bit/32-register and a
//                16-bit/8-register instance share clock, reset and stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regalu_pipe;

    localparam logic [5:0] c_F_ADD = 6'h20;
    localparam logic [5:0] c_F_SUB = 6'h22;
    localparam logic [5:0] c_F_AND = 6'h24;
    localparam logic [5:0] c_F_OR  = 6'h25;
    localparam logic [5:0] c_F_XOR = 6'h26;
    localparam logic [5:0] c_F_NOR = 6'h27;
    localparam logic [5:0] c_F_SLT = 6'h2A;
    localparam logic [5:0] c_F_SLL = 6'h00;
    localparam logic [5:0] c_F_SRL = 6'h02;

`ifdef REGALU_FORWARDING_EN
    localparam int c_DEP_STALLS = 0;
`else
    localparam int c_DEP_STALLS = 2;
`endif

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] res;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [4:0]  dbg_raddr;
    bit          sel;

    logic        rdy_a, ov_a, wen_a, ovf_a;
    logic [4:0]  rd_a;
    logic [31:0] res_a, dbg_a;
    logic        rdy_b, ov_b, wen_b, ovf_b;
    logic [4:0]  rd_b;
    logic [15:0] res_b, dbg_b;

    logic        obs_ready, obs_valid, obs_wen, obs_ovf;
    logic [4:0]  obs_rd;
    logic [63:0] obs_res, obs_dbg;

    exp_t        sbq[$];
    logic [63:0] mreg [0:1][0:31];
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          st;

    always #5 clk = ~clk;

    regalu_pipe #(.DATA_W(32), .NUM_REGS(32)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(rdy_a),
        .in_instr(in_instr), .out_valid(ov_a), .out_wen(wen_a), .out_rd(rd_a),
        .out_result(res_a), .out_ovf(ovf_a), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_a)
    );

    regalu_pipe #(.DATA_W(16), .NUM_REGS(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(rdy_b),
        .in_instr(in_instr), .out_valid(ov_b), .out_wen(wen_b), .out_rd(rd_b),
        .out_result(res_b), .out_ovf(ovf_b), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_b)
    );

    assign obs_ready = sel ? rdy_b : rdy_a;
    assign obs_valid = sel ? ov_b  : ov_a;
    assign obs_wen   = sel ? wen_b : wen_a;
    assign obs_ovf   = sel ? ovf_b : ovf_a;
    assign obs_rd    = sel ? rd_b  : rd_a;
    assign obs_res   = sel ? {48'd0, res_b} : {32'd0, res_a};
    assign obs_dbg   = sel ? {48'd0, dbg_b} : {32'd0, dbg_a};

    function automatic logic [31:0] rins(input logic [5:0] fn, input int rd, input int rs,
                                         input int rt, input int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    // Architectural reference: sequential execution against mreg of the selected instance
    function automatic exp_t model(input logic [31:0] ins);
        exp_t        e;
        int          w, nr;
        logic [63:0] mask, a, b, r;
        logic        ok, ov;
        logic [4:0]  rs, rt, rd, sh;
        w    = sel ? 16 : 32;
        nr   = sel ? 8 : 32;
        mask = (64'd1 << w) - 64'd1;
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
        a  = ((rs != 5'd0) && (int'(rs) < nr)) ? mreg[sel][rs] : 64'd0;
        b  = ((rt != 5'd0) && (int'(rt) < nr)) ? mreg[sel][rt] : 64'd0;
        ok = (ins[31:26] == 6'd0);
        r  = 64'd0;
        ov = 1'b0;
        case (ins[5:0])
            c_F_ADD: begin r = (a + b) & mask; ov = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]); end
            c_F_SUB: begin r = (a - b) & mask; ov = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]); end
            c_F_AND: r = a & b;
            c_F_OR:  r = a | b;
            c_F_XOR: r = a ^ b;
            c_F_NOR: r = ~(a | b) & mask;
            c_F_SLT: r = ($signed(a << (64 - w)) < $signed(b << (64 - w))) ? 64'd1 : 64'd0;
            c_F_SLL: r = (int'(sh) >= w) ? 64'd0 : ((b << sh) & mask);
            c_F_SRL: r = (int'(sh) >= w) ? 64'd0 : (b >> sh);
            default: ok = 1'b0;
        endcase
        if (!ok) begin r = 64'd0; ov = 1'b0; end
        e.due = 0;
        e.rd  = rd;
        e.wen = ok && (rd != 5'd0) && (int'(rd) < nr);
        e.res = r;
        e.ovf = ov;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if ((sbq.size() != 0) && (sbq[0].due == cyc)) begin
            e = sbq.pop_front();
            chk("out_valid",  {63'd0, obs_valid}, 64'd1);
            chk("out_rd",     {59'd0, obs_rd},    {59'd0, e.rd});
            chk("out_wen",    {63'd0, obs_wen},   {63'd0, e.wen});
            chk("out_result", obs_res,            e.res);
            chk("out_ovf",    {63'd0, obs_ovf},   {63'd0, e.ovf});
        end else begin
            chk("out_valid_idle", {63'd0, obs_valid}, 64'd0);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [31:0] ins, output int stalls);
        exp_t e;
        bit   done;
        done     = 1'b0;
        stalls   = 0;
        in_valid = 1'b1;
        in_instr = ins;
        for (int k = 0; (k < 12) && !done; k++) begin
            @(negedge clk);
            check_outputs();
            if (obs_ready) begin
                e     = model(ins);
                e.due = cyc + 2;
                sbq.push_back(e);
                if (e.wen) mreg[sel][e.rd] = e.res;
                done = 1'b1;
            end else begin
                stalls++;
            end
            advance();
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check_outputs();
            advance();
        end
    endtask

    task automatic chk_dbg(input int addr, input logic [63:0] exp);
        @(negedge clk);
        check_outputs();
        dbg_raddr = 5'(addr);
        #1;
        chk($sformatf("dbg_r%0d", addr), obs_dbg, exp);
        advance();
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 32; i++) mreg[s][i] = 64'd0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        dbg_raddr = 5'd0;
        sel       = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("in_ready_after_rst", {63'd0, obs_ready}, 64'd1);
        chk("out_valid_after_rst", {63'd0, obs_valid}, 64'd0);
        advance();
        for (int i = 0; i < 32; i++) chk_dbg(i, 64'd0);

        // Build r1=15, r2=10 from all-ones, then add r3
        issue(rins(c_F_NOR, 20, 0, 0, 0), st);
        issue(rins(c_F_SRL, 1, 0, 20, 28), st);
        issue(rins(c_F_SRL, 21, 0, 20, 31), st);
        issue(rins(c_F_SLL, 22, 0, 21, 1), st);
        issue(rins(c_F_SLL, 23, 0, 21, 3), st);
        issue(rins(c_F_OR, 2, 22, 23, 0), st);
        idle(3);
        issue(rins(c_F_ADD, 3, 1, 2, 0), st);
        idle(2);
        chk_dbg(3, 64'd25);

        // Back-to-back dependency
        idle(2);
        issue(rins(c_F_ADD, 4, 3, 3, 0), st);
        chk("stall_independent", 64'(st), 64'd0);
        issue(rins(c_F_SUB, 5, 4, 1, 0), st);
        chk("stall_dependent", 64'(st), 64'(c_DEP_STALLS));
        idle(3);
        chk_dbg(4, 64'd50);
        chk_dbg(5, 64'd35);

        // Signed overflow, slt, r0 write
        issue(rins(c_F_SRL, 1, 0, 20, 1), st);
        issue(rins(c_F_ADD, 2, 21, 0, 0), st);
        issue(rins(c_F_ADD, 6, 1, 2, 0), st);
        issue(rins(c_F_SLT, 7, 6, 2, 0), st);
        issue(rins(c_F_SUB, 8, 6, 2, 0), st);
        issue(rins(c_F_ADD, 0, 1, 2, 0), st);
        issue(rins(c_F_AND, 9, 1, 20, 0), st);
        issue(rins(c_F_XOR, 10, 1, 20, 0), st);
        idle(3);
        chk_dbg(6, 64'h8000_0000);
        chk_dbg(7, 64'd1);
        chk_dbg(8, 64'h7FFF_FFFF);
        chk_dbg(0, 64'd0);

        // Unsupported funct and opcode, with bubbles between
        issue(rins(6'h3F, 11, 1, 2, 0), st);
        idle(1);
        issue({6'h08, 26'(rins(c_F_ADD, 12, 1, 2, 0))}, st);
        idle(3);
        chk_dbg(11, 64'd0);
        chk_dbg(12, 64'd0);

        // Reset with two instructions in flight
        issue(rins(c_F_ADD, 12, 1, 2, 0), st);
        issue(rins(c_F_ADD, 13, 1, 1, 0), st);
        rst = 1'b1;
        @(negedge clk);
        check_outputs();
        chk("in_ready_in_rst", {63'd0, obs_ready}, 64'd0);
        advance();
        sbq.delete();
        clear_model();
        @(negedge clk);
        chk("rst_out_valid", {63'd0, obs_valid}, 64'd0);
        chk("rst_out_wen", {63'd0, obs_wen}, 64'd0);
        chk("rst_out_result", obs_res, 64'd0);
        advance();
        rst = 1'b0;
        chk_dbg(12, 64'd0);
        chk_dbg(1, 64'd0);

        // 16-bit / 8-register instance
        sel = 1'b1;
        issue(rins(c_F_NOR, 1, 0, 0, 0), st);
        issue(rins(c_F_SRL, 2, 0, 1, 15), st);
        issue(rins(c_F_ADD, 3, 1, 2, 0), st);
        issue(rins(c_F_SLL, 4, 0, 1, 20), st);
        issue(rins(c_F_SRL, 5, 0, 1, 20), st);
        issue(rins(c_F_SLL, 6, 0, 1, 4), st);
        issue(rins(c_F_ADD, 9, 2, 2, 0), st);
        issue(rins(c_F_ADD, 7, 9, 2, 0), st);
        idle(3);
        chk_dbg(3, 64'd0);
        chk_dbg(4, 64'd0);
        chk_dbg(6, 64'hFFF0);
        chk_dbg(9, 64'd0);
        chk_dbg(7, 64'd1);
        idle(2);

        if (sbq.size() != 0) chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
